// File: rtl/cix32_descriptor_loader_pkg.sv
// Shared types and constants for the segment descriptor loader.
// Descriptor bit positions index the access byte (attrs) or the high descriptor word.
package cix32_descriptor_loader_pkg;

  typedef enum logic {
    MODE_REAL      = 1'b0,
    MODE_PROTECTED = 1'b1
  } cpu_mode_t;

  typedef enum logic [2:0] {
    SEG_ES = 3'd0,
    SEG_CS = 3'd1,
    SEG_SS = 3'd2,
    SEG_DS = 3'd3,
    SEG_FS = 3'd4,
    SEG_GS = 3'd5
  } seg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_LO,
    ST_RD_HI,
    ST_VALIDATE,
    ST_COMMIT,
    ST_FAULT
  } loader_state_t;

  localparam logic [7:0] FV_NP = 8'd11;
  localparam logic [7:0] FV_SS = 8'd12;
  localparam logic [7:0] FV_GP = 8'd13;

  localparam int unsigned DESC_P    = 7;
  localparam int unsigned DESC_S    = 4;
  localparam int unsigned DESC_CODE = 3;
  localparam int unsigned DESC_RW   = 1;
  localparam int unsigned DESC_G    = 23;

  // Expands the 20-bit raw limit to bytes when the granularity bit is set.
  function automatic logic [31:0] desc_limit_decode(input logic [31:0] lo, input logic [31:0] hi);
    logic [19:0] raw;
    raw = {hi[19:16], lo[15:0]};
    return hi[DESC_G] ? {raw, 12'hFFF} : {12'h000, raw};
  endfunction

endpackage

// File: rtl/cix32_desc_check.sv
// Combinational type/presence validation of a fetched descriptor access byte.
module cix32_desc_check
  import cix32_descriptor_loader_pkg::*;
(
  input  logic [7:0] attrs,
  input  logic [2:0] seg,
  output logic       ok,
  output logic [7:0] vec
);

  logic is_cs;
  logic is_ss;
  logic type_bad;

  always_comb begin
    is_cs = (seg == SEG_CS);
    is_ss = (seg == SEG_SS);
    // Any type violation outranks the present check and always reports #GP.
    type_bad = !attrs[DESC_S]
             | (is_cs & !attrs[DESC_CODE])
             | (is_ss & (attrs[DESC_CODE] | !attrs[DESC_RW]))
             | (!is_cs & !is_ss & attrs[DESC_CODE] & !attrs[DESC_RW]);
    ok  = !type_bad & attrs[DESC_P];
    if (type_bad)  vec = FV_GP;
    else if (is_ss) vec = FV_SS;
    else            vec = FV_NP;
  end

endmodule

// File: rtl/cix32_descriptor_loader.sv
// Segment register / hidden descriptor cache loader: synthesizes real-mode
// descriptors and fetches/validates protected-mode descriptors from the GDT/LDT.
module cix32_descriptor_loader
  import cix32_descriptor_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  cpu_mode_t   cpu_mode,
  input  logic        load_req,
  input  logic [2:0]  load_seg,
  input  logic [15:0] load_sel,
  output logic        load_ready,
  input  logic [31:0] gdtr_base,
  input  logic [31:0] ldtr_base,
  input  logic [15:0] gdtr_limit,
  input  logic [15:0] ldtr_limit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata,
  output logic        seg_we,
  output logic [2:0]  seg_addr,
  output logic [15:0] seg_wdata,
  output logic        desc_we,
  output logic [2:0]  desc_seg,
  output logic [31:0] desc_base,
  output logic [31:0] desc_limit,
  output logic [7:0]  desc_attrs,
  output logic        done,
  output logic        fault,
  output logic [7:0]  fault_vec,
  output logic [15:0] fault_code
);

  loader_state_t state, state_next;

  logic [2:0]  seg_r;
  logic [15:0] sel_r;
  logic [31:0] lo_r;
  logic [31:0] addr_r;
  logic [31:0] base_r;
  logic [31:0] limit_r;
  logic [7:0]  attrs_r;
  logic [7:0]  fault_vec_r;
  logic [15:0] fault_code_r;

  logic [12:0] idx;
  logic        null_sel;
  logic        null_fatal;
  logic        out_of_bounds;
  logic [31:0] tbl_base;
  logic [15:0] tbl_limit;
  logic        chk_ok;
  logic [7:0]  chk_vec;
  logic        unused_desc_bits;

  assign unused_desc_bits = ^mem_rdata[22:20];

  always_comb begin
    idx           = sel_r[15:3];
    null_sel      = (sel_r[15:2] == 14'd0);
    null_fatal    = (seg_r == SEG_CS) || (seg_r == SEG_SS);
    tbl_base      = sel_r[2] ? ldtr_base  : gdtr_base;
    tbl_limit     = sel_r[2] ? ldtr_limit : gdtr_limit;
    out_of_bounds = {idx, 3'b111} > tbl_limit;
  end

  cix32_desc_check u_check (
    .attrs (attrs_r),
    .seg   (seg_r),
    .ok    (chk_ok),
    .vec   (chk_vec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:
        if (load_req) state_next = (cpu_mode == MODE_REAL) ? ST_COMMIT : ST_CHECK;
      ST_CHECK:
        if (null_sel)           state_next = null_fatal ? ST_FAULT : ST_COMMIT;
        else if (out_of_bounds) state_next = ST_FAULT;
        else                    state_next = ST_RD_LO;
      ST_RD_LO:
        if (mem_err)      state_next = ST_FAULT;
        else if (mem_ack) state_next = ST_RD_HI;
      ST_RD_HI:
        if (mem_err)      state_next = ST_FAULT;
        else if (mem_ack) state_next = ST_VALIDATE;
      ST_VALIDATE:
        state_next = chk_ok ? ST_COMMIT : ST_FAULT;
      ST_COMMIT, ST_FAULT:
        state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r        <= '0;
      sel_r        <= '0;
      lo_r         <= '0;
      addr_r       <= '0;
      base_r       <= '0;
      limit_r      <= '0;
      attrs_r      <= '0;
      fault_vec_r  <= '0;
      fault_code_r <= '0;
    end else begin
      unique case (state)
        ST_IDLE:
          if (load_req) begin
            seg_r   <= load_seg;
            sel_r   <= load_sel;
            base_r  <= {12'h000, load_sel, 4'h0};
            limit_r <= 32'h0000FFFF;
            attrs_r <= 8'h93;
          end
        ST_CHECK: begin
          // Zeroed so a null selector commits a not-present descriptor.
          addr_r  <= tbl_base + {16'h0000, idx, 3'b000};
          base_r  <= '0;
          limit_r <= '0;
          attrs_r <= '0;
        end
        ST_RD_LO:
          if (mem_ack && !mem_err) begin
            lo_r   <= mem_rdata;
            addr_r <= addr_r + 32'd4;
          end
        ST_RD_HI:
          if (mem_ack && !mem_err) begin
            base_r  <= {mem_rdata[31:24], mem_rdata[7:0], lo_r[31:16]};
            limit_r <= desc_limit_decode(lo_r, mem_rdata);
            attrs_r <= mem_rdata[15:8];
          end
        default: ;
      endcase
      if (state_next == ST_FAULT) begin
        fault_vec_r  <= (state == ST_VALIDATE) ? chk_vec : FV_GP;
        fault_code_r <= (state == ST_CHECK && null_sel) ? 16'h0000 : {sel_r[15:2], 2'b00};
      end
    end
  end

  always_comb begin
    load_ready = (state == ST_IDLE);
    mem_req    = (state == ST_RD_LO) || (state == ST_RD_HI);
    mem_addr   = addr_r;
    seg_we     = (state == ST_COMMIT);
    desc_we    = (state == ST_COMMIT);
    done       = (state == ST_COMMIT) || (state == ST_FAULT);
    fault      = (state == ST_FAULT);
    seg_addr   = '0;
    seg_wdata  = '0;
    desc_seg   = '0;
    desc_base  = '0;
    desc_limit = '0;
    desc_attrs = '0;
    if (state == ST_COMMIT) begin
      seg_addr   = seg_r;
      seg_wdata  = sel_r;
      desc_seg   = seg_r;
      desc_base  = base_r;
      desc_limit = limit_r;
      desc_attrs = attrs_r;
    end
    fault_vec  = fault_vec_r;
    fault_code = fault_code_r;
  end

endmodule

// File: tb/tb_cix32_descriptor_loader.sv
// Scoreboard bench for cix32_descriptor_loader with a wait-state memory responder.
module tb_cix32_descriptor_loader;
  import cix32_descriptor_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  cpu_mode_t   cpu_mode = MODE_REAL;
  logic        load_req = 1'b0;
  logic [2:0]  load_seg = '0;
  logic [15:0] load_sel = '0;
  logic        load_ready;
  logic [31:0] gdtr_base = 32'h0000_1000;
  logic [31:0] ldtr_base = 32'h0000_2000;
  logic [15:0] gdtr_limit = 16'h00FF;
  logic [15:0] ldtr_limit = 16'h000F;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        seg_we;
  logic [2:0]  seg_addr;
  logic [15:0] seg_wdata;
  logic        desc_we;
  logic [2:0]  desc_seg;
  logic [31:0] desc_base;
  logic [31:0] desc_limit;
  logic [7:0]  desc_attrs;
  logic        done;
  logic        fault;
  logic [7:0]  fault_vec;
  logic [15:0] fault_code;

  cix32_descriptor_loader dut (
    .clk(clk), .rst_n(rst_n), .cpu_mode(cpu_mode),
    .load_req(load_req), .load_seg(load_seg), .load_sel(load_sel), .load_ready(load_ready),
    .gdtr_base(gdtr_base), .ldtr_base(ldtr_base), .gdtr_limit(gdtr_limit), .ldtr_limit(ldtr_limit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .seg_we(seg_we), .seg_addr(seg_addr), .seg_wdata(seg_wdata),
    .desc_we(desc_we), .desc_seg(desc_seg), .desc_base(desc_base), .desc_limit(desc_limit),
    .desc_attrs(desc_attrs), .done(done), .fault(fault), .fault_vec(fault_vec), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_fault;
    logic [2:0]  seg;
    logic [15:0] sel;
    logic [31:0] base;
    logic [31:0] limit;
    logic [7:0]  attrs;
    logic [7:0]  vec;
    logic [15:0] code;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ea[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wait_states = 0;
  int          wcnt = 0;
  logic        err_once = 1'b0;
  logic        suppress = 1'b0;
  logic        mem_req_seen = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic exp_t mk_c(logic [2:0] s, logic [15:0] sel, logic [31:0] b, logic [31:0] l, logic [7:0] a);
    exp_t e;
    e = '{is_fault: 1'b0, seg: s, sel: sel, base: b, limit: l, attrs: a, vec: 8'h0, code: 16'h0, cyc: 0};
    return e;
  endfunction

  function automatic exp_t mk_f(logic [7:0] v, logic [15:0] c);
    exp_t e;
    e = '{is_fault: 1'b1, seg: 3'd0, sel: 16'h0, base: 32'h0, limit: 32'h0, attrs: 8'h0, vec: v, code: c, cyc: 0};
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (suppress) begin
      wcnt = 0;
    end else begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
      if (mem_req) begin
        if (wcnt == wait_states) begin
          wcnt = 0;
          if (err_once) begin
            mem_err  = 1'b1;
            err_once = 1'b0;
          end else begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
          end
          if (ea.size() == 0) chk("mem_addr_unexpected", mem_addr, 32'hFFFF_FFFF);
          else                chk("mem_addr", mem_addr, ea.pop_front());
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  exp_t m;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) mem_req_seen = 1'b1;
      if (done || fault || seg_we || desc_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {28'h0, done, fault, seg_we, desc_we}, 32'h0);
        end else begin
          m = sb.pop_front();
          chk("done_cycle", cyc, m.cyc);
          chk("done", done, 1);
          chk("fault", fault, m.is_fault);
          chk("seg_we", seg_we, !m.is_fault);
          chk("desc_we", desc_we, !m.is_fault);
          if (m.is_fault) begin
            chk("fault_vec", fault_vec, m.vec);
            chk("fault_code", fault_code, m.code);
          end else begin
            chk("seg_addr", seg_addr, m.seg);
            chk("desc_seg", desc_seg, m.seg);
            chk("seg_wdata", seg_wdata, m.sel);
            chk("desc_base", desc_base, m.base);
            chk("desc_limit", desc_limit, m.limit);
            chk("desc_attrs", desc_attrs, m.attrs);
          end
        end
      end
    end
  end

  // Caller is #1 after a posedge with the DUT idle; lat counts cycles from accept to done.
  task automatic run(input logic prot, input logic [2:0] s, input logic [15:0] sel,
                     input exp_t e, input int lat, input int hold);
    cpu_mode = prot ? MODE_PROTECTED : MODE_REAL;
    load_seg = s;
    load_sel = sel;
    load_req = 1'b1;
    @(posedge clk); #1;
    e.cyc = cyc + lat - 1;
    sb.push_back(e);
    load_seg = SEG_GS;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    load_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
    chk("ready_after_done", load_ready, 1);
  endtask

  initial begin
    mem[32'h1010] = 32'h0000_FFFF; mem[32'h1014] = 32'h00CF_9300;
    mem[32'h1018] = 32'h1234_5678; mem[32'h101C] = 32'h0000_1300;
    mem[32'h1020] = 32'h0000_FFFF; mem[32'h1024] = 32'h0000_9800;
    mem[32'h2008] = 32'hABCD_0010; mem[32'h200C] = 32'h1240_9A56;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_we", {seg_we, desc_we}, 0);
    chk("rst_desc_base", desc_base, 0);
    chk("rst_fault_vec", fault_vec, 0);
    chk("rst_fault_code", fault_code, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, SEG_DS, 16'h1234, mk_c(SEG_DS, 16'h1234, 32'h0001_2340, 32'h0000_FFFF, 8'h93), 1, 0);

    ea.push_back(32'h1010); ea.push_back(32'h1014);
    run(1, SEG_DS, 16'h0010, mk_c(SEG_DS, 16'h0010, 32'h0, 32'hFFFF_FFFF, 8'h93), 5, 0);

    mem_req_seen = 1'b0;
    run(1, SEG_DS, 16'h0100, mk_f(FV_GP, 16'h0100), 2, 0);
    chk("bounds_no_mem_req", mem_req_seen, 0);

    mem_req_seen = 1'b0;
    run(1, SEG_SS, 16'h0003, mk_f(FV_GP, 16'h0000), 2, 0);
    run(1, SEG_ES, 16'h0000, mk_c(SEG_ES, 16'h0000, 32'h0, 32'h0, 8'h00), 2, 0);
    chk("null_no_mem_req", mem_req_seen, 0);

    ea.push_back(32'h1018); ea.push_back(32'h101C);
    run(1, SEG_SS, 16'h0018, mk_f(FV_SS, 16'h0018), 5, 0);
    ea.push_back(32'h1018); ea.push_back(32'h101C);
    run(1, SEG_DS, 16'h001B, mk_f(FV_NP, 16'h0018), 5, 0);

    ea.push_back(32'h1020); ea.push_back(32'h1024);
    run(1, SEG_FS, 16'h0020, mk_f(FV_GP, 16'h0020), 5, 0);

    ea.push_back(32'h10F8); ea.push_back(32'h10FC);
    run(1, SEG_DS, 16'h00F8, mk_f(FV_GP, 16'h00F8), 5, 0);

    wait_states = 1;
    ea.push_back(32'h2008); ea.push_back(32'h200C);
    run(1, SEG_CS, 16'h000C, mk_c(SEG_CS, 16'h000C, 32'h1256_ABCD, 32'h0000_0010, 8'h9A), 7, 2);
    wait_states = 0;

    run(1, SEG_ES, 16'h0014, mk_f(FV_GP, 16'h0014), 2, 0);

    err_once = 1'b1;
    ea.push_back(32'h1010);
    run(1, SEG_DS, 16'h0011, mk_f(FV_GP, 16'h0010), 3, 0);

    // Reset while the second word is still waiting for its ack.
    wait_states = 3;
    ea.push_back(32'h1010); ea.push_back(32'h1014);
    cpu_mode = MODE_PROTECTED; load_seg = SEG_DS; load_sel = 16'h0010; load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (mem_req && mem_addr == 32'h1014) seen = 1'b1;
      end
      chk("reach_rd_hi", seen, 1);
    end
    @(posedge clk); #1;
    suppress = 1'b1; mem_ack = 1'b0; mem_err = 1'b0;
    rst_n = 1'b0;
    sb.delete(); ea.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_load_ready", load_ready, 1);
    mem_ack = 1'b1;
    mem_rdata = 32'h00CF_9300;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    suppress = 1'b0;
    wait_states = 0;
    chk("stray_ack_idle", load_ready, 1);

    run(0, SEG_FS, 16'hFFFF, mk_c(SEG_FS, 16'hFFFF, 32'h000F_FFF0, 32'h0000_FFFF, 8'h93), 1, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cix32_descriptor_loader.md
# cix32_descriptor_loader

Fills the segment register file and its hidden descriptor cache whenever a segment register is loaded, acting as the writer for the per-segment selector/base/limit/attrs state that address generation reads. It sits between the decode/execute control (load requests) and the memory read port. In real mode it synthesizes the descriptor directly. In protected mode it fetches the 8-byte descriptor from the GDT or LDT, validates it, and commits it or raises a fault.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- cpu_mode  in  cpu_mode_t  MODE_REAL / MODE_PROTECTED; sampled at request acceptance
- load_req  in  1  segment-load request
- load_seg  in  3  target segment, SEG_ES..SEG_GS encoding
- load_sel  in  16  selector value
- load_ready  out  1  high only in IDLE
- gdtr_base / ldtr_base  in  32  table bases
- gdtr_limit / ldtr_limit  in  16  table byte limits
- mem_req  out  1  read request, held until mem_ack or mem_err
- mem_addr  out  32  read address, stable while mem_req
- mem_ack  in  1  read data valid
- mem_err  in  1  bus error, terminates the read
- mem_rdata  in  32  read data
- seg_we / seg_addr / seg_wdata  out  1/3/16  selector write to the segment register file
- desc_we  out  1  hidden-cache write strobe
- desc_seg  out  3  cache entry
- desc_base  out  32  cache base value
- desc_limit  out  32  cache limit value
- desc_attrs  out  8  cache access byte
- done  out  1  one-cycle completion pulse (commit or fault)
- fault  out  1  one-cycle pulse together with done on failure
- fault_vec  out  8  fault vector
- fault_code  out  16  fault error code

## Operation
- States: IDLE, CHECK, RD_LO, RD_HI, VALIDATE, COMMIT, FAULT.
- Acceptance: load_req && load_ready latches seg, sel and mode. A request seen while busy is ignored; it is not queued.
- Real mode path: IDLE→COMMIT.
  - base = {12'h0, sel, 4'h0}, limit = 32'h0000FFFF, attrs = 8'h93.
- Protected mode path: IDLE→CHECK.
- Table selection: sel[2] (TI) selects LDT=1 / GDT=0. index = sel[15:3].
- Null selector (sel[15:2]==0):
  - CS or SS target: FAULT, vector 13, code 0.
  - Any other target: COMMIT with base 0, limit 0, attrs 8'h00 (not present). No memory access.
- Bounds check: ({index,3'b111}) > table limit (zero-extended) → FAULT, vector 13, code sel&16'hFFFC.
- Otherwise CHECK→RD_LO.
  - RD_LO address = table_base + {index,3'b000}.
  - RD_HI address = RD_LO address + 4.
  - Each state holds until ack; 32-bit adds wrap.
- mem_err in RD_LO or RD_HI → FAULT, vector 13, code sel&FFFC.
- Decode (lo = first word, hi = second word):
  - base = {hi[31:24], hi[7:0], lo[31:16]}
  - raw limit = {hi[19:16], lo[15:0]}; when G (hi[23]) is set, limit = {raw,12'hFFF}, else zero-extended.
  - attrs = hi[15:8]
- VALIDATE checks, in priority order:
  1. S bit (attrs[4]) = 0 → #GP (vector 13).
  2. CS requires code (attrs[3]=1).
  3. SS requires writable data (attrs[3]=0, attrs[1]=1).
  4. ES/DS/FS/GS reject execute-only code (attrs[3]=1, attrs[1]=0).
  5. Present (attrs[7]) = 0 → #SS (vector 12) for SS, #NP (vector 11) otherwise.
  - All checks use code sel&FFFC.
  - Pass → COMMIT.
- COMMIT (one cycle): seg_we, desc_we and done asserted; seg_wdata = sel; seg_addr = desc_seg = seg. Then → IDLE.
- FAULT (one cycle): done, fault, fault_vec and fault_code asserted; no register writes. Then → IDLE.
- No privilege (CPL/DPL/RPL) checks.

## Timing
- Reset values: state IDLE; load_ready 1; every other output 0.
- Reset mid-fetch drops mem_req in the next cycle. mem_ack/mem_err are sampled only in RD_LO/RD_HI, so a late ack is ignored.
- Accept at clock edge N:
  - Real mode: COMMIT in cycle N+1.
  - Protected, zero-wait memory (ack in the first cycle of each read): COMMIT or VALIDATE-fault in cycle N+5. Each wait state adds one cycle.
  - Null selector or bounds fault: decided in CHECK, FAULT in cycle N+2.
- load_ready rises in the cycle after COMMIT/FAULT. The earliest next accept is that cycle.
- fault_vec and fault_code hold their value until the next FAULT; they are only meaningful while fault=1.

## Structure
- Add to the shared defines package:
  - loader state enum
  - vector constants FV_NP=11, FV_SS=12, FV_GP=13
  - descriptor bit positions (DESC_P=7, DESC_S=4, DESC_CODE=3, DESC_RW=1, DESC_G=23)
- Sub-module cix32_desc_check: combinational; takes attrs and seg, returns ok/vector. The FSM, address generation and decode live in the top module.

## Test plan
- Real mode, load DS sel 16'h1234 → COMMIT in cycle N+1, desc_base 32'h00012340, limit 32'h0000FFFF, attrs 8'h93.
- Protected, GDT base 32'h1000, limit 16'h00FF, sel 16'h0010, memory 32'h0000FFFF / 32'h00CF9300 → reads at 0x1010 and 0x1014, commit base 0, limit 32'hFFFFFFFF, attrs 8'h93, at cycle N+5.
- Sel 16'h0100 against gdtr_limit 16'h00FF → FAULT vector 13, code 16'h0100, mem_req never asserted.
- Null sel into SS → #GP code 0; null sel into ES → commit with attrs 8'h00.
- SS load of a descriptor with attrs 8'h13 (not present) → vector 12. The same descriptor into DS → vector 11.
- 3-cycle ack delay, then rst_n low during RD_HI → IDLE with mem_req 0; a subsequent stray mem_ack causes no write.
